// File: rtl/la_pkg.sv
// Shared logic-analyser constants and state encodings for la_ctrl and the
// data_path_la benches.
package la_pkg;

    localparam int LA_DEPTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR     = 3'd1,
        ST_ARMED   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_STORE   = 3'd4,
        ST_DONE    = 3'd5
    } la_state_e;

endpackage

// File: rtl/la_ctrl.sv
// Logic-analyser capture controller: arm, wait for trigger, write N samples,
// strobe status. Optional early abort on STOP when LA_ABORT_EN is defined.
module la_ctrl
    import la_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ARM,
    input  logic       TRIG,
    input  logic [4:0] LEN,
    input  logic       STOP,
    output logic       LA_WE,
    output logic       STS_CE,
    output logic       BUSY,
    output logic       DONE,
    output logic [2:0] STATE
);

    la_state_e  r_state;
    la_state_e  w_next;
    logic [4:0] r_len;
    logic [5:0] r_cnt;
    logic       r_la_we;
    logic       r_sts_ce;
    logic [5:0] w_n;
    logic       w_stop;

`ifdef LA_ABORT_EN
    assign w_stop = STOP;
`else
    logic w_unused_stop;
    assign w_unused_stop = STOP;
    assign w_stop        = 1'b0;
`endif

    // LEN of zero selects the full buffer depth.
    assign w_n = (r_len == 5'd0) ? 6'(LA_DEPTH) : {1'b0, r_len};

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (ARM) w_next = ST_CLR;
            end
            ST_CLR: w_next = ST_ARMED;
            ST_ARMED: begin
                if (w_stop)    w_next = ST_STORE;
                else if (TRIG) w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (w_stop || (r_cnt == (w_n - 6'd1))) w_next = ST_STORE;
            end
            ST_STORE: w_next = ST_DONE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state  <= ST_IDLE;
            r_len    <= 5'd0;
            r_cnt    <= 6'd0;
            r_la_we  <= 1'b0;
            r_sts_ce <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_la_we  <= (w_next == ST_CAPTURE);
            r_sts_ce <= (w_next == ST_CLR) || (w_next == ST_STORE);
            if (((r_state == ST_IDLE) || (r_state == ST_DONE)) && ARM)
                r_len <= LEN;
            if (r_state == ST_CAPTURE)
                r_cnt <= r_cnt + 6'd1;
            else
                r_cnt <= 6'd0;
        end
    end

    assign LA_WE  = r_la_we;
    assign STS_CE = r_sts_ce;
    assign STATE  = r_state;
    assign DONE   = (r_state == ST_DONE);
    assign BUSY   = (r_state == ST_CLR) || (r_state == ST_ARMED) ||
                    (r_state == ST_CAPTURE) || (r_state == ST_STORE);

endmodule

// File: tb/tb_la_ctrl.sv
// Directed bench for la_ctrl with a small datapath model (5-bit sample
// counter and status register) driven by LA_WE / STS_CE.
module tb_la_ctrl;

    logic       CLK;
    logic       RESET;
    logic       ARM;
    logic       TRIG;
    logic [4:0] LEN;
    logic       STOP;
    logic       LA_WE;
    logic       STS_CE;
    logic       BUSY;
    logic       DONE;
    logic [2:0] STATE;

    int total = 0;
    int bad   = 0;

    int         we_cnt;
    int         ce_cnt;
    logic [4:0] dp_cnt;
    logic [4:0] dp_status;
    logic       both_seen;

    la_ctrl dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .ARM    (ARM),
        .TRIG   (TRIG),
        .LEN    (LEN),
        .STOP   (STOP),
        .LA_WE  (LA_WE),
        .STS_CE (STS_CE),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .STATE  (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Datapath model, sampled away from the active edge.
    initial begin
        we_cnt = 0; ce_cnt = 0; dp_cnt = 5'd0; dp_status = 5'd0; both_seen = 1'b0;
    end
    always @(negedge CLK) begin
        if (LA_WE && STS_CE) both_seen = 1'b1;
        if (LA_WE) we_cnt++;
        if (STS_CE) ce_cnt++;
        if (STS_CE) begin
            dp_status = dp_cnt;
            dp_cnt    = 5'd0;
        end else if (LA_WE) begin
            dp_cnt = dp_cnt + 5'd1;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        we_cnt = 0;
        ce_cnt = 0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (DONE) break;
            step();
        end
        chk(tag, {31'd0, DONE}, 32'd1);
    endtask

    task automatic arm_and_trig(input logic [4:0] len);
        ARM = 1'b1; LEN = len;
        step();
        ARM = 1'b0;
        step();
        TRIG = 1'b1;
        step();
        TRIG = 1'b0;
    endtask

    initial begin
        RESET = 1'b0; ARM = 1'b0; TRIG = 1'b0; LEN = 5'd0; STOP = 1'b0;

        // Reset held for two cycles, then released.
        step(); step();
        chk("rst_state", {29'd0, STATE}, 32'd0);
        chk("rst_we",    {31'd0, LA_WE}, 32'd0);
        chk("rst_ce",    {31'd0, STS_CE}, 32'd0);
        RESET = 1'b1;
        step();
        chk("idle_state", {29'd0, STATE}, 32'd0);
        chk("idle_busy",  {31'd0, BUSY}, 32'd0);
        chk("idle_done",  {31'd0, DONE}, 32'd0);

        // LEN=5, trigger three cycles after arming.
        clr_counts();
        ARM = 1'b1; LEN = 5'd5;
        step();
        ARM = 1'b0; LEN = 5'd17;
        chk("clr_state", {29'd0, STATE}, 32'd1);
        chk("clr_ce",    {31'd0, STS_CE}, 32'd1);
        chk("clr_busy",  {31'd0, BUSY}, 32'd1);
        step();
        chk("armed_state", {29'd0, STATE}, 32'd2);
        chk("armed_ce",    {31'd0, STS_CE}, 32'd0);
        step(); step();
        chk("armed_wait_we", {31'd0, LA_WE}, 32'd0);
        TRIG = 1'b1;
        step();
        TRIG = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("cap_we", {31'd0, LA_WE}, 32'd1);
            chk("cap_state", {29'd0, STATE}, 32'd3);
            step();
        end
        chk("store_state", {29'd0, STATE}, 32'd4);
        chk("store_ce",    {31'd0, STS_CE}, 32'd1);
        chk("store_we",    {31'd0, LA_WE}, 32'd0);
        step();
        chk("done5", {31'd0, DONE}, 32'd1);
        chk("done5_busy", {31'd0, BUSY}, 32'd0);
        step(); step();
        chk("done_hold", {31'd0, DONE}, 32'd1);
        chk("we5", we_cnt, 32'd5);
        chk("ce5", ce_cnt, 32'd2);
        chk("status5", {27'd0, dp_status}, 32'd5);

        // LEN=0 means a full 32-sample capture; 5-bit status wraps to 0.
        clr_counts();
        arm_and_trig(5'd0);
        wait_done("done32");
        chk("we32", we_cnt, 32'd32);
        chk("status32", {27'd0, dp_status}, 32'd0);

        // ARM, LEN and TRIG churn during capture must not alter the length.
        clr_counts();
        arm_and_trig(5'd7);
        for (int i = 0; i < 5; i++) begin
            ARM = ~ARM; TRIG = ~TRIG; LEN = 5'd3;
            step();
        end
        ARM = 1'b0; TRIG = 1'b0;
        wait_done("done7");
        chk("we7", we_cnt, 32'd7);
        chk("status7", {27'd0, dp_status}, 32'd7);

        // STOP raised during the 4th write cycle.
        clr_counts();
        arm_and_trig(5'd10);
        step(); step(); step();
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        wait_done("done_stop");
`ifdef LA_ABORT_EN
        chk("we_stop", we_cnt, 32'd4);
        chk("status_stop", {27'd0, dp_status}, 32'd4);
`else
        chk("we_stop", we_cnt, 32'd10);
        chk("status_stop", {27'd0, dp_status}, 32'd10);
`endif

        // Reset in the 3rd capture cycle, then a clean re-arm.
        clr_counts();
        arm_and_trig(5'd8);
        step(); step();
        chk("cap3_we", {31'd0, LA_WE}, 32'd1);
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        chk("rstcap_we",    {31'd0, LA_WE}, 32'd0);
        chk("rstcap_state", {29'd0, STATE}, 32'd0);
        chk("rstcap_ce",    {31'd0, STS_CE}, 32'd0);
        step();
        chk("rstcap_ce_count", ce_cnt, 32'd1);
        chk("rstcap_we_count", we_cnt, 32'd3);
        clr_counts();
        arm_and_trig(5'd3);
        wait_done("done_rearm");
        chk("we_rearm", we_cnt, 32'd3);
        chk("status_rearm", {27'd0, dp_status}, 32'd3);

        chk("no_overlap", {31'd0, both_seen}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
